// File: rtl/alu_pkg.sv
// Shared types and constants for the 8-bit datapath ALU.
// Opcode encoding is owned by the control/microcode unit.
package alu_pkg;

    localparam int W   = 8;
    localparam int OPW = 4;

    typedef enum logic [OPW-1:0] {
        ADD = 4'd0,
        SUB = 4'd1,
        AND = 4'd2,
        NOR = 4'd3,
        XOR = 4'd4,
        SHR = 4'd5,
        SHL = 4'd6,
        EQ  = 4'd7,
        NE  = 4'd8,
        GT  = 4'd9,
        LT  = 4'd10
    } op_t;

endpackage

// File: rtl/alu_flags.sv
// Status flags derived from the ALU result.
// Purely combinational; no state.
module alu_flags
    import alu_pkg::*;
(
    input  logic [W-1:0] result,
    output logic         zero,
    output logic         parity,
    output logic         odd
);

    // Zero, XOR-reduction parity and LSB taken straight from the result
    always_comb begin
        zero   = (result == '0);
        parity = ^result;
        odd    = result[0];
    end

endmodule

// File: rtl/alu.sv
// 8-bit combinational ALU with one registered carry/shift-out bit.
// Out and flags have zero latency; SC_out updates on Clk.
module alu
    import alu_pkg::*;
(
    input  logic           Clk,
    input  logic           Reset,
    input  logic [W-1:0]   InputA,
    input  logic [W-1:0]   InputB,
    input  logic           SC_in,
    input  logic [OPW-1:0] OP,
    output logic [W-1:0]   Out,
    output logic           Zero,
    output logic           Parity,
    output logic           Odd,
    output logic           SC_out
);

    logic [W:0] sum;
    logic [W:0] diff;
    logic [W:0] shr_ext;
    logic [W:0] shl_ext;
    logic       sc_next;

    // Widened by one bit so the carry/borrow and last shifted-out
    // bit fall out of the same operation as the result.
    // For shifts, B = 0 or B > 8 leaves the extra bit clear.
    assign sum     = {1'b0, InputA} + {1'b0, InputB} + {{W{1'b0}}, SC_in};
    assign diff    = {1'b0, InputA} - {1'b0, InputB} - {{W{1'b0}}, SC_in};
    assign shr_ext = {InputA, 1'b0} >> InputB;
    assign shl_ext = {1'b0, InputA} << InputB;

    // Result mux and next carry; non-carry ops hold SC_out
    always_comb begin
        Out     = '0;
        sc_next = SC_out;
        case (OP)
            ADD: begin
                Out     = sum[W-1:0];
                sc_next = sum[W];
            end
            SUB: begin
                Out     = diff[W-1:0];
                sc_next = diff[W];
            end
            AND: Out = InputA & InputB;
            NOR: Out = ~(InputA | InputB);
            XOR: Out = InputA ^ InputB;
            SHR: begin
                Out     = shr_ext[W:1];
                sc_next = shr_ext[0];
            end
            SHL: begin
                Out     = shl_ext[W-1:0];
                sc_next = shl_ext[W];
            end
            EQ:  Out = {{(W-1){1'b0}}, InputA == InputB};
            NE:  Out = {{(W-1){1'b0}}, InputA != InputB};
            GT:  Out = {{(W-1){1'b0}}, InputA > InputB};
            LT:  Out = {{(W-1){1'b0}}, InputA < InputB};
            default: Out = '0;
        endcase
    end

    // Carry register; Reset wins over any op in the same cycle
    always_ff @(posedge Clk) begin
        if (Reset) begin
            SC_out <= 1'b0;
        end else begin
            SC_out <= sc_next;
        end
    end

    alu_flags u_flags (
        .result (Out),
        .zero   (Zero),
        .parity (Parity),
        .odd    (Odd)
    );

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: driver and carry model push expectations,
// a monitor pops and compares them against the DUT outputs.
module tb_alu;

    logic       Clk;
    logic       Reset;
    logic [7:0] InputA;
    logic [7:0] InputB;
    logic       SC_in;
    logic [3:0] OP;
    logic [7:0] Out;
    logic       Zero;
    logic       Parity;
    logic       Odd;
    logic       SC_out;

    typedef struct {
        bit         is_sc;
        logic [7:0] out;
        logic       zero;
        logic       parity;
        logic       odd;
        logic       sc;
        string      name;
    } exp_t;

    exp_t expq[$];
    event mon_ev;
    int   checks   = 0;
    int   failures = 0;
    int   model_sc = 0;

    alu dut (
        .Clk    (Clk),
        .Reset  (Reset),
        .InputA (InputA),
        .InputB (InputB),
        .SC_in  (SC_in),
        .OP     (OP),
        .Out    (Out),
        .Zero   (Zero),
        .Parity (Parity),
        .Odd    (Odd),
        .SC_out (SC_out)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Reference: result and carry from plain integer arithmetic.
    // upd = 0 means this opcode leaves the carry register alone.
    function automatic void ref_model(
        input  int a, input int b, input int c, input int op,
        output int out, output int sc_n, output bit upd
    );
        int r;
        out  = 0;
        sc_n = 0;
        upd  = 1'b0;
        case (op)
            0: begin
                r    = a + b + c;
                out  = r % 256;
                sc_n = (r >= 256) ? 1 : 0;
                upd  = 1'b1;
            end
            1: begin
                r    = a - b - c;
                out  = (r + 512) % 256;
                sc_n = (r < 0) ? 1 : 0;
                upd  = 1'b1;
            end
            2: out = a & b;
            3: out = 255 - (a | b);
            4: out = a ^ b;
            5: begin
                out  = (b < 8) ? a / (2 ** b) : 0;
                sc_n = (b >= 1 && b <= 8) ? (a / (2 ** (b - 1))) % 2 : 0;
                upd  = 1'b1;
            end
            6: begin
                out  = (b < 8) ? (a * (2 ** b)) % 256 : 0;
                sc_n = (b >= 1 && b <= 8) ? (a / (2 ** (8 - b))) % 2 : 0;
                upd  = 1'b1;
            end
            7:  out = (a == b) ? 1 : 0;
            8:  out = (a != b) ? 1 : 0;
            9:  out = (a > b) ? 1 : 0;
            10: out = (a < b) ? 1 : 0;
            default: out = 0;
        endcase
    endfunction

    function automatic exp_t mk_out(input int out, input string name);
        exp_t e;
        e.is_sc  = 1'b0;
        e.out    = 8'(out);
        e.zero   = (out == 0);
        e.parity = ($countones(8'(out)) % 2) == 1;
        e.odd    = (out % 2) == 1;
        e.sc     = 1'b0;
        e.name   = name;
        return e;
    endfunction

    // Drive between clock edges; push the given (or model) result, sample 1 ns later
    task automatic apply(
        input logic [7:0] a, input logic [7:0] b, input logic c,
        input logic [3:0] op, input logic rst,
        input bit use_exp, input int exp_out, input string name
    );
        int m_out;
        int m_sc;
        bit m_upd;
        @(negedge Clk);
        InputA = a;
        InputB = b;
        SC_in  = c;
        OP     = op;
        Reset  = rst;
        ref_model(int'(a), int'(b), int'(c), int'(op), m_out, m_sc, m_upd);
        #1;
        expq.push_back(mk_out(use_exp ? exp_out : m_out, name));
        ->mon_ev;
    endtask

    // Carry model: capture at every edge, check 1 ns later
    initial begin
        int m_out;
        int m_sc;
        bit m_upd;
        exp_t e;
        forever begin
            @(posedge Clk);
            ref_model(int'(InputA), int'(InputB), int'(SC_in), int'(OP),
                      m_out, m_sc, m_upd);
            if (Reset === 1'b1) model_sc = 0;
            else if (m_upd) model_sc = m_sc;
            #1;
            e       = mk_out(0, "sc_out");
            e.is_sc = 1'b1;
            e.sc    = model_sc[0];
            expq.push_back(e);
            ->mon_ev;
        end
    end

    // Monitor: drain the scoreboard and compare with what the DUT shows now
    initial begin
        exp_t e;
        forever begin
            @(mon_ev);
            while (expq.size() > 0) begin
                e = expq.pop_front();
                if (e.is_sc) begin
                    checks++;
                    if (SC_out !== e.sc) begin
                        failures++;
                        $display("FAIL %s: SC_out=%b want %b", e.name, SC_out, e.sc);
                    end
                end else begin
                    checks++;
                    if (Out !== e.out) begin
                        failures++;
                        $display("FAIL %s: Out=%h want %h (A=%h B=%h OP=%0d C=%b)",
                                 e.name, Out, e.out, InputA, InputB, OP, SC_in);
                    end
                    checks++;
                    if ({Zero, Parity, Odd} !== {e.zero, e.parity, e.odd}) begin
                        failures++;
                        $display("FAIL %s flags: ZPO=%b%b%b want %b%b%b",
                                 e.name, Zero, Parity, Odd,
                                 e.zero, e.parity, e.odd);
                    end
                end
            end
        end
    end

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        InputA = 8'h00;
        InputB = 8'h00;
        SC_in  = 1'b0;
        OP     = 4'd2;
        Reset  = 1'b1;
        repeat (2) @(posedge Clk);

        begin
            int tbl [11] = '{5, 3, 0, 250, 5, 2, 8, 0, 1, 1, 0};
            for (int i = 0; i < 11; i++) begin
                apply(8'h04, 8'h01, 1'b0, 4'(i), 1'b0, 1'b1, tbl[i], "a4b1");
            end
        end

        apply(8'hFF, 8'h01, 1'b0, 4'd0, 1'b0, 1'b1, 8'h00, "add_wrap");
        apply(8'hFF, 8'h01, 1'b0, 4'd2, 1'b0, 1'b1, 8'h01, "and_hold");
        apply(8'h00, 8'h01, 1'b0, 4'd1, 1'b0, 1'b1, 8'hFF, "sub_wrap");
        apply(8'h05, 8'h02, 1'b1, 4'd1, 1'b0, 1'b1, 8'h02, "sub_bin");
        apply(8'h81, 8'h01, 1'b0, 4'd6, 1'b0, 1'b1, 8'h02, "shl1");
        apply(8'h81, 8'h09, 1'b0, 4'd5, 1'b0, 1'b1, 8'h00, "shr9");
        apply(8'h81, 8'h08, 1'b0, 4'd5, 1'b0, 1'b1, 8'h00, "shr8");
        apply(8'h81, 8'h08, 1'b0, 4'd6, 1'b0, 1'b1, 8'h00, "shl8");
        apply(8'h81, 8'h00, 1'b0, 4'd5, 1'b0, 1'b1, 8'h81, "shr0");
        apply(8'h81, 8'h01, 1'b0, 4'd12, 1'b0, 1'b1, 8'h00, "op12");
        apply(8'hFF, 8'h01, 1'b0, 4'd0, 1'b1, 1'b1, 8'h00, "rst_add");
        apply(8'h00, 8'h00, 1'b0, 4'd2, 1'b0, 1'b1, 8'h00, "post_rst");

        for (int i = 0; i < 400; i++) begin
            ra = 8'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 10))
                                             : 8'($urandom);
            apply(ra, rb, 1'($urandom), 4'($urandom_range(0, 15)),
                  ($urandom_range(0, 15) == 0), 1'b0, 0, "rand");
        end

        repeat (3) @(posedge Clk);
        #2;
        checks++;
        if (expq.size() != 0) begin
            failures++;
            $display("FAIL drain: pending=%0d want 0", expq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
